rr_arbiter8: RTL

//  - 8-way round-robin arbiter that shares one resource between eight requesters.
//  - Produces a registered 3-bit grant index plus enable, which is the select/enable pair of a 3-to-8 decoder.
//  - Also produces the equivalent one-hot grant vector.
//  - Sits between the requester logic and the shared decoder/datapath, and sequences ownership cycle by cycle.

---
 rtl/arb_pkg.sv | 12 +
 rtl/onehot_dec3.sv | 17 +
 rtl/rr_arbiter8.sv | 124 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned ARB_N     = 8;
    localparam int unsigned ARB_IDX_W = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 decoder with enable: turns the registered grant index/valid pair into a one-hot vector.
module onehot_dec3
    import arb_pkg::*;
(
    input  logic                 en,
    input  logic [ARB_IDX_W-1:0] idx,
    output logic [ARB_N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered grant index/valid and one-hot grant.
// Optional forced revocation after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ARB_N-1:0]     REQ,
    input  logic                 DONE,
    output logic                 GNT_VALID,
    output logic [ARB_IDX_W-1:0] GNT_IDX,
    output logic [ARB_N-1:0]     GNT,
    output logic                 TIMEOUT
);

    arb_state_e           state_q, state_d;
    logic [ARB_IDX_W-1:0] idx_q, idx_d;
    logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
    logic [ARB_IDX_W-1:0] pick_c;
    logic                 release_c;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    function automatic logic [ARB_IDX_W-1:0] rr_pick(input logic [ARB_N-1:0]     req,
                                                     input logic [ARB_IDX_W-1:0] ptr);
        logic [ARB_N-1:0]     rot;
        logic [ARB_IDX_W-1:0] first;
        logic                 found;
        rot   = (req >> ptr) | (req << (ARB_N - ptr));
        first = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ARB_N; i++) begin
            if (rot[i] && !found) begin
                first = ARB_IDX_W'(i);
                found = 1'b1;
            end
        end
        return first + ptr;
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             hold_exp_c;
    assign hold_exp_c = (cnt_q == CNT_W'(HOLD_MAX - 1));
`endif

    assign pick_c    = rr_pick(REQ, ptr_q);
    assign release_c = DONE | ~REQ[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (|REQ) begin
                    state_d = ARB_GRANT;
                    idx_d   = pick_c;
                    ptr_d   = pick_c + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_GRANT: begin
                // A real release takes precedence; TIMEOUT flags only forced revocation.
                if (release_c) begin
                    state_d = ARB_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_exp_c) begin
                    state_d   = ARB_IDLE;
                    timeout_d = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign GNT_VALID = (state_q == ARB_GRANT);
    assign GNT_IDX   = idx_q;

`ifdef ARB_TIMEOUT_EN
    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    onehot_dec3 u_dec (
        .en     (GNT_VALID),
        .idx    (GNT_IDX),
        .onehot (GNT)
    );

endmodule
